// File: rtl/write_back_stage_ext.sv
// write_back_stage_ext: MIPS-DLX write-back with load extraction, commit history and retired counter
module write_back_stage_ext #(
    parameter int NB_DATA       = 32,
    parameter int NB_REG        = 5,
    parameter int NB_ADDR       = 7,
    parameter int NB_MEM_TO_REG = 2,
    parameter int HIST_DEPTH    = 8,
    parameter int NB_COUNT      = 16,
    localparam int NB_HIST      = $clog2(HIST_DEPTH)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_stall,
    input  logic                     i_reg_write,
    input  logic [NB_REG-1:0]        i_write_register,
    input  logic [NB_DATA-1:0]       i_mem_data,
    input  logic [NB_DATA-1:0]       i_alu_result,
    input  logic [NB_ADDR-1:0]       i_pc,
    input  logic [NB_DATA-1:0]       i_inm_ext,
    input  logic [NB_MEM_TO_REG-1:0] i_mem_to_reg,
    input  logic [1:0]               i_load_size,
    input  logic                     i_load_unsigned,
    input  logic [1:0]               i_byte_offset,
    input  logic [NB_HIST-1:0]       i_hist_index,
    output logic                     o_valid,
    output logic                     o_reg_write,
    output logic [NB_REG-1:0]        o_write_register,
    output logic [NB_DATA-1:0]       o_data,
    output logic [NB_REG-1:0]        o_hist_register,
    output logic [NB_DATA-1:0]       o_hist_data,
    output logic [NB_HIST:0]         o_hist_count,
    output logic [NB_COUNT-1:0]      o_retired_count
);
    localparam logic [NB_HIST:0] HIST_FULL = HIST_DEPTH[NB_HIST:0];

    logic [NB_REG-1:0]  hist_reg  [HIST_DEPTH];
    logic [NB_DATA-1:0] hist_data [HIST_DEPTH];
    logic [NB_HIST-1:0] wr_ptr;
    logic [NB_HIST-1:0] rd_ptr;
    logic               rd_hit;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [NB_DATA-1:0] ld_data;
    logic [NB_DATA-1:0] result;
    logic               commit;
    logic               log_write;

    // little-endian sub-word extraction and result-source selection
    always_comb begin
        ld_byte = i_mem_data[{i_byte_offset, 3'b000} +: 8];
        ld_half = i_byte_offset[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        ld_data = i_load_size[1] ? i_mem_data
                : i_load_size[0] ? {{(NB_DATA-16){~i_load_unsigned & ld_half[15]}}, ld_half}
                : {{(NB_DATA-8){~i_load_unsigned & ld_byte[7]}}, ld_byte};
        result = i_mem_to_reg == 2'b00 ? ld_data
               : i_mem_to_reg == 2'b01 ? i_alu_result
               : i_mem_to_reg == 2'b10 ? {{(NB_DATA-NB_ADDR){1'b0}}, i_pc}
               : i_inm_ext;
        commit    = i_valid & ~i_stall;
        log_write = commit & i_reg_write & (i_write_register != '0);
    end

    // newest-first history read; entries beyond the fill level read as zero
    always_comb begin
        rd_ptr          = wr_ptr - NB_HIST'(1) - i_hist_index;
        rd_hit          = {1'b0, i_hist_index} < o_hist_count;
        o_hist_register = rd_hit ? hist_reg[rd_ptr] : '0;
        o_hist_data     = rd_hit ? hist_data[rd_ptr] : '0;
    end

    // result register, retirement counter and circular commit log
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_valid          <= 1'b0;
            o_reg_write      <= 1'b0;
            o_write_register <= '0;
            o_data           <= '0;
            o_retired_count  <= '0;
            o_hist_count     <= '0;
            wr_ptr           <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_reg[k]  <= '0;
                hist_data[k] <= '0;
            end
        end else begin
            o_valid     <= commit;
            o_reg_write <= log_write;
            if (commit) begin
                o_data           <= result;
                o_write_register <= i_write_register;
                o_retired_count  <= o_retired_count + 1'b1;
            end
            if (log_write) begin
                hist_reg[wr_ptr]  <= i_write_register;
                hist_data[wr_ptr] <= result;
                wr_ptr            <= wr_ptr + 1'b1;
                if (o_hist_count != HIST_FULL)
                    o_hist_count <= o_hist_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_write_back_stage_ext.sv
// tb_write_back_stage_ext: randomized and directed checks against a queue-based reference model
module tb_write_back_stage_ext;
    localparam int NBC = 4;

    logic        clock = 0;
    logic        reset_n;
    logic        valid, stall, reg_write, load_unsigned;
    logic [4:0]  write_register;
    logic [31:0] mem_data, alu_result, inm_ext;
    logic [6:0]  pc;
    logic [1:0]  mem_to_reg, load_size, byte_offset;
    logic [2:0]  hist_index;
    logic        o_valid, o_reg_write;
    logic [4:0]  o_write_register, o_hist_register;
    logic [31:0] o_data, o_hist_data;
    logic [3:0]  o_hist_count;
    logic [NBC-1:0] o_retired_count;

    int total = 0;
    int bad = 0;

    typedef struct packed { logic [4:0] r; logic [31:0] d; } entry_t;
    entry_t      hq[$];
    logic        m_valid, m_rw;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_retired;

    write_back_stage_ext #(.NB_COUNT(NBC)) dut (
        .i_clock(clock), .i_reset(reset_n), .i_valid(valid), .i_stall(stall),
        .i_reg_write(reg_write), .i_write_register(write_register),
        .i_mem_data(mem_data), .i_alu_result(alu_result), .i_pc(pc), .i_inm_ext(inm_ext),
        .i_mem_to_reg(mem_to_reg), .i_load_size(load_size), .i_load_unsigned(load_unsigned),
        .i_byte_offset(byte_offset), .i_hist_index(hist_index),
        .o_valid(o_valid), .o_reg_write(o_reg_write), .o_write_register(o_write_register),
        .o_data(o_data), .o_hist_register(o_hist_register), .o_hist_data(o_hist_data),
        .o_hist_count(o_hist_count), .o_retired_count(o_retired_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_result();
        longint v;
        if (mem_to_reg == 1) return alu_result;
        if (mem_to_reg == 2) return 32'(pc);
        if (mem_to_reg == 3) return inm_ext;
        if (load_size >= 2) return mem_data;
        if (load_size == 0) begin
            v = (longint'(mem_data) >> (8 * byte_offset)) % 256;
            if (!load_unsigned && v >= 128) v -= 256;
        end else begin
            v = (longint'(mem_data) >> (byte_offset >= 2 ? 16 : 0)) % 65536;
            if (!load_unsigned && v >= 32768) v -= 65536;
        end
        return v[31:0];
    endfunction

    function automatic entry_t ref_hist(int i);
        return i < hq.size() ? hq[i] : '0;
    endfunction

    // advance the model on the current inputs, then clock the DUT
    task automatic tick();
        if (!reset_n) begin
            hq = {};
            m_valid = 0; m_rw = 0; m_reg = 0; m_data = 0; m_retired = 0;
        end else if (valid && !stall) begin
            m_valid = 1;
            m_rw = reg_write && write_register != 0;
            m_reg = write_register;
            m_data = ref_result();
            m_retired = (m_retired + 1) % (1 << NBC);
            if (m_rw) begin
                hq.push_front('{r: write_register, d: m_data});
                if (hq.size() > 8) void'(hq.pop_back());
            end
        end else begin
            m_valid = 0; m_rw = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic v, input logic s, input logic rw, input logic [4:0] r,
                          input logic [1:0] sel);
        valid = v; stall = s; reg_write = rw; write_register = r; mem_to_reg = sel;
    endtask

    task automatic do_reset();
        reset_n = 0; set_op(0, 0, 0, 0, 0);
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        mem_data = 32'hDEAD_BEEF; alu_result = 32'h1111; inm_ext = 0; pc = 0;
        load_size = 2; load_unsigned = 0; byte_offset = 0; hist_index = 0;
        do_reset();
        #1;
        total++;
        if ({o_valid, o_reg_write, o_write_register, o_data, o_hist_count, o_retired_count,
             o_hist_register, o_hist_data} !== '0) begin
            bad++;
            $display("FAIL reset: valid=%b rw=%b reg=%0d data=%h cnt=%0d ret=%0d hist=%0d/%h want all 0",
                     o_valid, o_reg_write, o_write_register, o_data, o_hist_count, o_retired_count,
                     o_hist_register, o_hist_data);
        end
    endtask

    task automatic test_alu_commit();
        alu_result = 32'h1234;
        set_op(1, 0, 1, 5, 2'b01);
        tick();
        hist_index = 0;
        #1;
        total++;
        if (o_data !== 32'h1234 || o_write_register !== 5 || o_reg_write !== 1 || o_valid !== 1 ||
            o_hist_count !== 1 || o_hist_register !== 5 || o_hist_data !== 32'h1234 ||
            o_retired_count !== 1) begin
            bad++;
            $display("FAIL alu_commit: data=%h reg=%0d rw=%b v=%b cnt=%0d h=%0d/%h ret=%0d want 1234/5/1/1/1/5/1234/1",
                     o_data, o_write_register, o_reg_write, o_valid, o_hist_count,
                     o_hist_register, o_hist_data, o_retired_count);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz  [5] = '{0, 0, 1, 1, 2};
        logic        uns [5] = '{0, 1, 0, 1, 0};
        logic [1:0]  off [5] = '{2, 2, 3, 0, 1};
        logic [31:0] exp [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_7F01, 32'h80F0_7F01};
        mem_data = 32'h80F0_7F01;
        for (int i = 0; i < 5; i++) begin
            load_size = sz[i]; load_unsigned = uns[i]; byte_offset = off[i];
            set_op(1, 0, 1, 5'(i + 1), 2'b00);
            tick();
            total++;
            if (o_data !== exp[i]) begin
                bad++;
                $display("FAIL load_%0d: got %h want %h", i, o_data, exp[i]);
            end
        end
    endtask

    task automatic test_zero_reg_and_pc();
        int cnt0 = int'(o_hist_count);
        int ret0 = int'(o_retired_count);
        alu_result = 32'hABCD;
        set_op(1, 0, 1, 0, 2'b01);
        tick();
        total++;
        if (o_reg_write !== 0 || o_valid !== 1 || int'(o_hist_count) != cnt0 ||
            int'(o_retired_count) != (ret0 + 1) % 16) begin
            bad++;
            $display("FAIL zero_reg: rw=%b v=%b cnt=%0d ret=%0d want 0/1/%0d/%0d",
                     o_reg_write, o_valid, o_hist_count, o_retired_count, cnt0, (ret0 + 1) % 16);
        end
        pc = 7'h45;
        set_op(1, 0, 1, 9, 2'b10);
        tick();
        total++;
        if (o_data !== 32'h0000_0045) begin
            bad++;
            $display("FAIL pc_source: got %h want 00000045", o_data);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held = o_data;
        int ret0 = int'(o_retired_count);
        alu_result = 32'h5555_AAAA;
        set_op(1, 1, 1, 12, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (o_valid !== 0 || o_reg_write !== 0 || o_data !== held || int'(o_retired_count) != ret0) begin
                bad++;
                $display("FAIL stall_%0d: v=%b rw=%b data=%h ret=%0d want 0/0/%h/%0d",
                         i, o_valid, o_reg_write, o_data, o_retired_count, held, ret0);
            end
        end
        stall = 0;
        tick();
        set_op(0, 0, 0, 0, 2'b01);
        hist_index = 0;
        #1;
        total++;
        if (o_valid !== 1 || o_data !== 32'h5555_AAAA || int'(o_retired_count) != (ret0 + 1) % 16 ||
            o_hist_register !== 12) begin
            bad++;
            $display("FAIL stall_release: v=%b data=%h ret=%0d h=%0d", o_valid, o_data, o_retired_count, o_hist_register);
        end
        tick();
        total++;
        if (o_valid !== 0 || int'(o_retired_count) != (ret0 + 1) % 16) begin
            bad++;
            $display("FAIL stall_single: v=%b ret=%0d want 0/%0d", o_valid, o_retired_count, (ret0 + 1) % 16);
        end
    endtask

    task automatic test_history_fill();
        do_reset();
        for (int r = 1; r <= 10; r++) begin
            alu_result = 32'h100 + 32'(r);
            set_op(1, 0, 1, 5'(r), 2'b01);
            tick();
        end
        set_op(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            hist_index = 3'(i);
            #1;
            total++;
            if (o_hist_count !== 8 || o_hist_register !== 5'(10 - i) || o_hist_data !== 32'h100 + 32'(10 - i)) begin
                bad++;
                $display("FAIL hist_fill_%0d: cnt=%0d reg=%0d data=%h want 8/%0d/%h",
                         i, o_hist_count, o_hist_register, o_hist_data, 10 - i, 32'h100 + 32'(10 - i));
            end
        end
        do_reset();
        hist_index = 0;
        #1;
        total++;
        if (o_hist_count !== 0 || o_hist_register !== 0 || o_hist_data !== 0) begin
            bad++;
            $display("FAIL hist_reset: cnt=%0d reg=%0d data=%h want 0", o_hist_count, o_hist_register, o_hist_data);
        end
    endtask

    task automatic test_retired_wrap();
        do_reset();
        alu_result = 32'h77;
        set_op(1, 0, 0, 3, 2'b01);
        for (int i = 0; i < 17; i++) tick();
        total++;
        if (o_retired_count !== 1) begin
            bad++;
            $display("FAIL retired_wrap: got %0d want 1", o_retired_count);
        end
    endtask

    task automatic test_reset_mid();
        alu_result = 32'hCAFE;
        set_op(1, 0, 1, 4, 2'b01);
        tick();
        reset_n = 0;
        tick();
        reset_n = 1;
        set_op(0, 0, 0, 0, 0);
        total++;
        if ({o_valid, o_reg_write, o_write_register, o_data, o_hist_count, o_retired_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: v=%b rw=%b reg=%0d data=%h cnt=%0d ret=%0d want 0",
                     o_valid, o_reg_write, o_write_register, o_data, o_hist_count, o_retired_count);
        end
    endtask

    task automatic test_random();
        entry_t e;
        for (int n = 0; n < 300; n++) begin
            reset_n = $urandom_range(0, 39) != 0;
            set_op($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                   5'($urandom_range(0, 7)), 2'($urandom));
            mem_data = $urandom; alu_result = $urandom; inm_ext = $urandom; pc = 7'($urandom);
            load_size = 2'($urandom); load_unsigned = 1'($urandom); byte_offset = 2'($urandom);
            tick();
            hist_index = 3'($urandom);
            #1;
            e = ref_hist(int'(hist_index));
            total++;
            if (o_valid !== m_valid || o_reg_write !== m_rw || o_write_register !== m_reg ||
                o_data !== m_data || int'(o_retired_count) != m_retired || int'(o_hist_count) != hq.size() ||
                o_hist_register !== e.r || o_hist_data !== e.d) begin
                bad++;
                $display("FAIL random_%0d: v=%b/%b rw=%b/%b reg=%0d/%0d data=%h/%h ret=%0d/%0d cnt=%0d/%0d h[%0d]=%0d:%h/%0d:%h",
                         n, o_valid, m_valid, o_reg_write, m_rw, o_write_register, m_reg, o_data, m_data,
                         o_retired_count, m_retired, o_hist_count, hq.size(), hist_index,
                         o_hist_register, o_hist_data, e.r, e.d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_commit();
        test_loads();
        test_zero_reg_and_pc();
        test_stall();
        test_history_fill();
        test_retired_wrap();
        test_reset_mid();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
